// File: rtl/filter_result_buffer.sv
// filter_result_buffer
//   Output stage of the filter datapath. Filtered result words are captured in
//   a small circular FIFO and offered to the PCIe transmit path over a
//   valid/ready handshake. A per-frame word count drives a RUN/DRAIN sequence
//   and a one-cycle frame_done pulse once the final word has left the buffer.
//
// Ports
//   clk        : system clock, rising-edge state updates
//   n_rst      : asynchronous active-low reset
//   start      : one-cycle frame start, honoured only in IDLE
//   frame_len  : words in the frame, sampled with an accepted start
//   in_valid   : result word present on in_data
//   in_data    : result word from the filter
//   in_ready   : buffer accepts in_data this cycle
//   out_valid  : out_data holds a valid word
//   out_data   : FIFO head word (0 when empty)
//   out_ready  : downstream accepts out_data this cycle
//   count      : FIFO occupancy
//   busy       : frame in progress (RUN or DRAIN)
//   frame_done : one-cycle pulse at end of frame
//   err        : sticky protocol error, cleared by an accepted start or reset
module filter_result_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       start,
  input  logic [LEN_WIDTH-1:0]       frame_len,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                 state_q,      state_d;
  logic [PTR_W-1:0]       wr_ptr_q,     wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q,     rd_ptr_d;
  logic [CNT_W-1:0]       count_q,      count_d;
  logic [LEN_WIDTH-1:0]   in_left_q,    in_left_d;
  logic [LEN_WIDTH-1:0]   out_left_q,   out_left_d;
  logic                   frame_done_q, frame_done_d;
  logic                   err_q,        err_d;

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

  logic push;
  logic pop;
  logic start_ok;
  logic err_set;

  // Handshake qualifiers are derived only from registered state, so there is
  // no combinational path from in_data/in_valid to any output.
  assign in_ready  = (state_q == RUN) && (count_q != CNT_W'(DEPTH)) && (in_left_q != '0);
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign busy      = (state_q != IDLE);
  assign count     = count_q;
  assign frame_done = frame_done_q;
  assign err       = err_q;

  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign start_ok = start && (state_q == IDLE);

  // out_left==0 with an empty FIFO while busy means the consumer is asking
  // for words that the frame will never deliver.
  assign err_set = (in_valid && ((state_q == IDLE) || (state_q == DRAIN)))
                || (out_ready && (out_left_q == '0) && (count_q == '0) && (state_q != IDLE));

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    in_left_d    = in_left_q;
    out_left_d   = out_left_q;
    frame_done_d = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (push && (in_left_q != '0))  in_left_d  = in_left_q  - LEN_WIDTH'(1);
    if (pop  && (out_left_q != '0)) out_left_d = out_left_q - LEN_WIDTH'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (frame_len != '0) begin
            in_left_d  = frame_len;
            out_left_d = frame_len;
            state_d    = RUN;
          end else begin
            frame_done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (push && (in_left_q == LEN_WIDTH'(1))) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && (out_left_q == LEN_WIDTH'(1))) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_ok) err_d = 1'b0;
    else          err_d = err_q | err_set;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      in_left_q    <= '0;
      out_left_q   <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      in_left_q    <= in_left_d;
      out_left_q   <= out_left_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  // Storage is not reset; out_data is masked to 0 whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_filter_result_buffer.sv
module tb_filter_result_buffer;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic [15:0] frame_len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [3:0]  count;
  logic        busy;
  logic        frame_done;
  logic        err;

  int   checks;
  int   errors;
  int   pushed;
  int   popped;
  logic do_push;
  logic do_pop;

  filter_result_buffer #(
    .DATA_WIDTH(32),
    .DEPTH     (8),
    .LEN_WIDTH (16)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .frame_len (frame_len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .busy      (busy),
    .frame_done(frame_done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    n_rst     = 1'b0;
    start     = 1'b0;
    frame_len = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_count",     32'(count),      32'd0);
    chk("rst_out_valid", 32'(out_valid),  32'd0);
    chk("rst_out_data",  out_data,        32'd0);
    chk("rst_in_ready",  32'(in_ready),   32'd0);
    chk("rst_busy",      32'(busy),       32'd0);
    chk("rst_done",      32'(frame_done), 32'd0);
    chk("rst_err",       32'(err),        32'd0);
    #9;
    n_rst = 1'b1;
    tick();

    // Basic frame of 4
    start = 1'b1; frame_len = 16'd4;
    tick();
    start = 1'b0;
    chk("bf_busy",     32'(busy),     32'd1);
    chk("bf_in_ready", 32'(in_ready), 32'd1);
    chk("bf_count0",   32'(count),    32'd0);
    in_valid = 1'b1; in_data = 32'hA1; out_ready = 1'b1;
    tick();
    chk("bf_w1", out_data, 32'hA1);
    chk("bf_c1", 32'(count), 32'd1);
    in_data = 32'hA2;
    tick();
    chk("bf_w2", out_data, 32'hA2);
    chk("bf_c2", 32'(count), 32'd1);
    in_data = 32'hA3;
    tick();
    chk("bf_w3", out_data, 32'hA3);
    in_data = 32'hA4;
    tick();
    in_valid = 1'b0;
    chk("bf_w4",       out_data,          32'hA4);
    chk("bf_drain_rdy", 32'(in_ready),    32'd0);
    chk("bf_drain_busy", 32'(busy),       32'd1);
    chk("bf_no_done",  32'(frame_done),   32'd0);
    tick();
    out_ready = 1'b0;
    chk("bf_done",     32'(frame_done), 32'd1);
    chk("bf_busy_end", 32'(busy),       32'd0);
    chk("bf_empty",    32'(out_valid),  32'd0);
    chk("bf_data0",    out_data,        32'd0);
    tick();
    chk("bf_done_off", 32'(frame_done), 32'd0);
    chk("bf_err",      32'(err),        32'd0);

    // Full / back-pressure, frame of 12 through an 8-deep FIFO
    start = 1'b1; frame_len = 16'd12;
    tick();
    start = 1'b0;
    pushed = 0;
    popped = 0;
    for (int cyc = 0; cyc < 80 && popped < 12; cyc++) begin
      if (cyc == 10) begin
        chk("bp_full_count", 32'(count),    32'd8);
        chk("bp_full_rdy",   32'(in_ready), 32'd0);
        chk("bp_head",       out_data,      32'hB00);
      end
      out_ready = (cyc >= 10);
      in_valid  = (pushed < 12);
      in_data   = 32'(32'hB00 + pushed);
      if (out_valid && out_ready) chk("bp_order", out_data, 32'(32'hB00 + popped));
      do_push = in_valid && in_ready;
      do_pop  = out_valid && out_ready;
      tick();
      if (do_push) pushed++;
      if (do_pop)  popped++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("bp_popped", 32'(popped),     32'd12);
    chk("bp_done",   32'(frame_done), 32'd1);
    chk("bp_busy",   32'(busy),       32'd0);
    chk("bp_err",    32'(err),        32'd0);
    tick();

    // Simultaneous push/pop, with an ignored start during a frame of 6
    start = 1'b1; frame_len = 16'd6;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'hC0;
    tick();
    in_data = 32'hC1; start = 1'b1; frame_len = 16'd2;
    tick();
    start = 1'b0; in_data = 32'hC2;
    tick();
    chk("sp_count3", 32'(count), 32'd3);
    chk("sp_head0",  out_data,   32'hC0);
    in_data = 32'hC3; out_ready = 1'b1;
    tick();
    chk("sp_count_same", 32'(count), 32'd3);
    chk("sp_head1",      out_data,   32'hC1);
    out_ready = 1'b0; in_data = 32'hC4;
    tick();
    in_data = 32'hC5;
    tick();
    in_valid = 1'b0;
    chk("sp_count5",   32'(count),    32'd5);
    chk("sp_six_only", 32'(in_ready), 32'd0);
    chk("sp_busy",     32'(busy),     32'd1);
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      chk("sp_order", out_data, 32'(32'hC0 + k));
      tick();
    end
    out_ready = 1'b0;
    chk("sp_done", 32'(frame_done), 32'd1);
    chk("sp_err",  32'(err),        32'd0);
    tick();

    // Zero-length frame
    start = 1'b1; frame_len = 16'd0;
    tick();
    start = 1'b0;
    chk("zl_done", 32'(frame_done), 32'd1);
    chk("zl_busy", 32'(busy),       32'd0);
    tick();
    chk("zl_done_off", 32'(frame_done), 32'd0);

    // Error flag: in_valid while IDLE, sticky until an accepted start
    in_valid = 1'b1; in_data = 32'hDEAD;
    tick();
    in_valid = 1'b0;
    chk("er_set",   32'(err),   32'd1);
    chk("er_nopush", 32'(count), 32'd0);
    tick();
    tick();
    chk("er_sticky", 32'(err), 32'd1);
    start = 1'b1; frame_len = 16'd1;
    tick();
    start = 1'b0;
    chk("er_clear", 32'(err), 32'd0);
    in_valid = 1'b1; in_data = 32'hD0;
    tick();
    tick();                       // in_valid still high while in DRAIN
    in_valid = 1'b0;
    chk("er_drain",       32'(err),   32'd1);
    chk("er_drain_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("er_frame_done", 32'(frame_done), 32'd1);
    chk("er_through",    32'(err),        32'd1);
    start = 1'b1; frame_len = 16'd0;
    tick();
    start = 1'b0;
    chk("er_clear0", 32'(err), 32'd0);
    tick();

    // Reset mid-frame
    start = 1'b1; frame_len = 16'd5;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 32'(32'hE0 + k);
      tick();
    end
    in_valid = 1'b0;
    chk("mr_pre_count", 32'(count), 32'd3);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mr_count", 32'(count),     32'd0);
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_busy",  32'(busy),      32'd0);
    chk("mr_done",  32'(frame_done), 32'd0);
    n_rst = 1'b1;
    tick();
    chk("mr_done_after", 32'(frame_done), 32'd0);
    start = 1'b1; frame_len = 16'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'hF0; out_ready = 1'b1;
    tick();
    chk("mr_w0", out_data, 32'hF0);
    in_data = 32'hF1;
    tick();
    in_valid = 1'b0;
    chk("mr_w1", out_data, 32'hF1);
    tick();
    out_ready = 1'b0;
    chk("mr_done_new", 32'(frame_done), 32'd1);
    chk("mr_busy_end", 32'(busy),       32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/filter_result_buffer.md
Name: filter_result_buffer

Overview:
- Downstream stage of the filter top level.
- Captures the 32-bit filtered result words in a small circular FIFO and presents them to the PCIe transmit path over a valid/ready handshake.
- Tracks a per-frame word count and pulses frame_done once the last word of a frame has been accepted downstream.
- Provides back-pressure to the filter feed through in_ready.

Parameters:
- DATA_WIDTH, 32, width of each result word.
- DEPTH, 8, FIFO entries; must be a power of two, minimum 2.
- LEN_WIDTH, 16, width of the frame-length field and the internal word counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- frame_len  input  LEN_WIDTH  words in the frame; sampled when start is accepted.
- in_valid  input  1  filter result word present on in_data.
- in_data  input  DATA_WIDTH  filter result word.
- in_ready  output  1  buffer accepts in_data this cycle.
- out_valid  output  1  out_data holds a valid word.
- out_data  output  DATA_WIDTH  word at the FIFO head.
- out_ready  input  1  downstream accepts out_data this cycle.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- busy  output  1  high in RUN or DRAIN.
- frame_done  output  1  one-cycle pulse at end of frame.
- err  output  1  sticky protocol error flag.

Behaviour:
- Reset (n_rst low, asynchronous):
  - State goes to IDLE; read/write pointers, count and both counters clear.
  - in_ready, out_valid, busy, frame_done and err all drive 0; out_data drives 0.
  - Reset asserted mid-frame discards all buffered words without a frame_done pulse.
- Handshakes:
  - A push occurs when in_valid && in_ready.
  - A pop occurs when out_valid && out_ready.
  - Both can occur in the same cycle; count is then unchanged and both pointers advance.
- in_ready = (state==RUN) && (count!=DEPTH) && (in_left!=0). A push is never accepted when the FIFO is full, even if a pop happens in the same cycle.
- out_valid = (count!=0), in any state.
  - out_data is the head entry, 0 when empty.
  - It is held stable while out_valid && !out_ready.
- Latency: a word pushed at edge t appears on out_data from t+1, at the earliest. There is no combinational bypass from in_data to out_data.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- IDLE:
  - start with frame_len!=0: load in_left=out_left=frame_len, go to RUN.
  - start with frame_len==0: pulse frame_done on the next cycle, stay in IDLE.
- RUN:
  - Each push decrements in_left; each pop decrements out_left.
  - When the push that takes in_left to 0 occurs, go to DRAIN.
- DRAIN:
  - in_ready is 0; pops continue.
  - The pop that takes out_left to 0 sets frame_done high on the next cycle for exactly one cycle, and state returns to IDLE in that same cycle.
- busy = (state!=IDLE).
- start is ignored while busy; this is not an error.
- err:
  - Set when in_valid is high in IDLE or DRAIN.
  - Set when out_ready is high with out_left==0 and count==0 while busy.
  - Set is a no-op in the cycle the condition is registered; err is cleared only by an accepted start or by reset.
- Counters saturate at 0 and never underflow.

Test Plan:
- Reset mid-frame:
  - Stimulus: frame_len=5, push 3 words, assert n_rst low asynchronously between clock edges.
  - Required: count=0, out_valid=0, busy=0 immediately; no frame_done pulse; next start runs normally.
- Basic frame:
  - Stimulus: start with frame_len=4, push 0xA1..0xA4 back-to-back, out_ready=1 throughout.
  - Required: each word appears on out_data one cycle after its push, in order; frame_done pulses once, one cycle after 0xA4 pops; busy then drops.
- Full/back-pressure:
  - Stimulus: frame_len=12, out_ready=0, in_valid=1 continuously.
  - Required: count reaches 8, in_ready drops, and out_data stays at word 0.
  - Stimulus: raise out_ready.
  - Required: all 12 words drain in order with pointer wrap; frame_done fires after word 12.
- Simultaneous push/pop:
  - Stimulus: with count=3, push and pop in the same cycle.
  - Required: count stays 3; head advances to the next word; the newly pushed word lands at the tail.
- Zero length and ignored start:
  - Stimulus: start with frame_len=0.
  - Required: frame_done one cycle later, busy stays 0.
  - Stimulus: during a frame of 6, pulse start with frame_len=2.
  - Required: still exactly 6 words accepted.
- Error flag:
  - Stimulus: in_valid=1 while IDLE.
  - Required: err=1 from the next cycle and stays set through a full frame; an accepted start clears it.
